// File: rtl/demux_4b_1_4_if.sv
// demux_4b_1_4_if: muxed input bus plus the four parallel channel outputs of the demux.
// DEMUX_SYNC_CHECK_EN adds the sticky sync_err flag to the bundle.
interface demux_4b_1_4_if #(parameter int W = 4);
  logic [W-1:0] d;
  logic         d_valid;
  logic         sync;
  logic [W-1:0] f0;
  logic [W-1:0] f1;
  logic [W-1:0] f2;
  logic [W-1:0] f3;
  logic [1:0]   sel;
  logic         frame_valid;
  logic         locked;
`ifdef DEMUX_SYNC_CHECK_EN
  logic         sync_err;
  modport master (output d, d_valid, sync, input f0, f1, f2, f3, sel, frame_valid, locked, sync_err);
  modport slave  (input d, d_valid, sync, output f0, f1, f2, f3, sel, frame_valid, locked, sync_err);
`else
  modport master (output d, d_valid, sync, input f0, f1, f2, f3, sel, frame_valid, locked);
  modport slave  (input d, d_valid, sync, output f0, f1, f2, f3, sel, frame_valid, locked);
`endif
endinterface

// File: rtl/demux_4b_1_4.sv
// demux_4b_1_4: splits a sync-framed 4-slot word stream into four double-buffered channels.
// DEMUX_SYNC_CHECK_EN adds a sticky sync_err for premature or missing frame syncs.
module demux_4b_1_4 #(parameter int W = 4) (
  input logic           clk,
  input logic           rst_n,
  demux_4b_1_4_if.slave bus
);
  typedef enum logic {HUNT, COLLECT} state_t;
  state_t              state_q, state_d;
  logic [1:0]          sel_q, sel_d;
  logic [2:0][W-1:0]   sh_q, sh_d;
  logic [3:0][W-1:0]   f_q, f_d;
  logic                fv_q, fv_d;
  logic                err_q, err_d;
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    sh_d    = sh_q;
    f_d     = f_q;
    fv_d    = 1'b0;
    err_d   = err_q;
    if (bus.d_valid) begin
      if (bus.sync) begin
        sh_d[0] = bus.d;
        sel_d   = 2'd1;
        state_d = COLLECT;
        err_d   = err_q | (state_q == COLLECT && sel_q != 2'd0);
      end else if (state_q == COLLECT) begin
        // slot 3 publishes the whole frame at once so f0..f3 stay coherent
        if (sel_q == 2'd3) begin
          f_d   = {bus.d, sh_q};
          fv_d  = 1'b1;
          sel_d = 2'd0;
        end else begin
          sh_d[sel_q] = bus.d;
          sel_d       = sel_q + 2'd1;
          err_d       = err_q | (sel_q == 2'd0);
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      sel_q   <= '0;
      sh_q    <= '0;
      f_q     <= '0;
      fv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      sh_q    <= sh_d;
      f_q     <= f_d;
      fv_q    <= fv_d;
      err_q   <= err_d;
    end
  end
  assign bus.f0          = f_q[0];
  assign bus.f1          = f_q[1];
  assign bus.f2          = f_q[2];
  assign bus.f3          = f_q[3];
  assign bus.sel         = sel_q;
  assign bus.frame_valid = fv_q;
  assign bus.locked      = state_q == COLLECT;
`ifdef DEMUX_SYNC_CHECK_EN
  assign bus.sync_err    = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif
endmodule

// File: tb/tb_demux_4b_1_4.sv
// tb_demux_4b_1_4: scoreboard bench; expected frames are queued as words are driven
// and popped whenever the DUT pulses frame_valid.
module tb_demux_4b_1_4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  int n_fv = 0;
  int fv_mark;
  logic [15:0] exp_q[$];
  demux_4b_1_4_if #(.W(4)) bus ();
  demux_4b_1_4 #(.W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  function automatic logic [15:0] fcat();
    return {bus.f3, bus.f2, bus.f1, bus.f0};
  endfunction
  always @(negedge clk) begin
    if (rst_n && bus.frame_valid) begin
      n_fv++;
      if (exp_q.size() == 0) chk("unexpected_fv", 32'd1, 32'd0);
      else chk("frame", {16'd0, fcat()}, {16'd0, exp_q.pop_front()});
    end
  end
  task automatic put(input logic [3:0] w, input logic s);
    bus.d = w;
    bus.sync = s;
    bus.d_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.d_valid = 1'b0;
    bus.sync = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    idle(1);
  endtask
  task automatic std_frame();
    put(4'h2, 1'b1);
    put(4'h9, 1'b0);
    put(4'h6, 1'b0);
    put(4'hB, 1'b0);
  endtask
  initial begin
    bus.d = '0;
    bus.d_valid = 1'b0;
    bus.sync = 1'b0;
    #2;
    chk("rst_f", {16'd0, fcat()}, 32'd0);
    chk("rst_sel", {30'd0, bus.sel}, 32'd0);
    chk("rst_fv", {31'd0, bus.frame_valid}, 32'd0);
    chk("rst_locked", {31'd0, bus.locked}, 32'd0);
    #4;
    rst_n = 1'b1;
    idle(1);
    // basic frame
    exp_q.push_back(16'hB692);
    fv_mark = n_fv;
    std_frame();
    chk("t1_fv", {31'd0, bus.frame_valid}, 32'd1);
    chk("t1_sel", {30'd0, bus.sel}, 32'd0);
    chk("t1_locked", {31'd0, bus.locked}, 32'd1);
    chk("t1_f", {16'd0, fcat()}, 32'h0000B692);
    idle(1);
    chk("t1_fv_drop", {31'd0, bus.frame_valid}, 32'd0);
    chk("t1_fv_count", n_fv - fv_mark, 32'd1);
    // hunt ignores unsynced words
    do_reset();
    for (int i = 0; i < 3; i++) put(4'hF, 1'b0);
    chk("t2_hunt_locked", {31'd0, bus.locked}, 32'd0);
    chk("t2_hunt_sel", {30'd0, bus.sel}, 32'd0);
    exp_q.push_back(16'hB692);
    fv_mark = n_fv;
    std_frame();
    idle(2);
    chk("t2_fv_count", n_fv - fv_mark, 32'd1);
    chk("t2_f", {16'd0, fcat()}, 32'h0000B692);
    // gaps between words
    do_reset();
    exp_q.push_back(16'hB692);
    put(4'h2, 1'b1); idle(2);
    put(4'h9, 1'b0); idle(2);
    put(4'h6, 1'b0); idle(2);
    chk("t3_f_hold", {16'd0, fcat()}, 32'd0);
    chk("t3_sel", {30'd0, bus.sel}, 32'd3);
    put(4'hB, 1'b0);
    chk("t3_fv", {31'd0, bus.frame_valid}, 32'd1);
    idle(1);
    // restart drops partial frame
    put(4'h1, 1'b1);
    put(4'h3, 1'b0);
`ifdef DEMUX_SYNC_CHECK_EN
    chk("t4_err_clean", {31'd0, bus.sync_err}, 32'd0);
`endif
    exp_q.push_back(16'hEC87);
    fv_mark = n_fv;
    put(4'h7, 1'b1);
    chk("t4_f_unchanged", {16'd0, fcat()}, 32'h0000B692);
    put(4'h8, 1'b0);
    put(4'hC, 1'b0);
    put(4'hE, 1'b0);
    idle(2);
    chk("t4_fv_count", n_fv - fv_mark, 32'd1);
    chk("t4_f", {16'd0, fcat()}, 32'h0000EC87);
`ifdef DEMUX_SYNC_CHECK_EN
    chk("t4_sync_err", {31'd0, bus.sync_err}, 32'd1);
`endif
    // asynchronous reset mid-frame
    put(4'h4, 1'b1);
    put(4'h5, 1'b0);
    chk("t5_sel_pre", {30'd0, bus.sel}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_f", {16'd0, fcat()}, 32'd0);
    chk("t5_async_sel", {30'd0, bus.sel}, 32'd0);
    chk("t5_async_locked", {31'd0, bus.locked}, 32'd0);
`ifdef DEMUX_SYNC_CHECK_EN
    chk("t5_async_err", {31'd0, bus.sync_err}, 32'd0);
`endif
    #2;
    rst_n = 1'b1;
    idle(1);
    exp_q.push_back(16'hB692);
    std_frame();
    idle(1);
    chk("t5_f", {16'd0, fcat()}, 32'h0000B692);
    // back-to-back frames, second without sync
    do_reset();
    exp_q.push_back(16'hDCBA);
    exp_q.push_back(16'h8765);
    fv_mark = n_fv;
    put(4'hA, 1'b1);
    put(4'hB, 1'b0);
    put(4'hC, 1'b0);
    put(4'hD, 1'b0);
    put(4'h5, 1'b0);
    put(4'h6, 1'b0);
    put(4'h7, 1'b0);
    put(4'h8, 1'b0);
    idle(2);
    chk("t6_fv_count", n_fv - fv_mark, 32'd2);
    chk("t6_f", {16'd0, fcat()}, 32'h00008765);
    chk("t6_locked", {31'd0, bus.locked}, 32'd1);
`ifdef DEMUX_SYNC_CHECK_EN
    chk("t6_sync_err", {31'd0, bus.sync_err}, 32'd1);
`endif
    chk("pending", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
